// File: rtl/bmat_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bmat_pkg                                                |
// | Purpose  : Shared constants, mode encoding and transpose helper    |
// |            for the 8x8 bit-matrix multiply unit.                   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package bmat_pkg;

    localparam int          XLEN          = 64;
    localparam int          BMAT_N        = 8;
    localparam logic [63:0] BMAT_IDENTITY = 64'h8040201008040201;

    // Reduction mode selected by xoren
    typedef enum logic {
        BMAT_OR  = 1'b0,
        BMAT_XOR = 1'b1
    } bmat_mode_e;

    // bmatflip: transpose an 8x8 bit matrix, element (i,j) <-> (j,i).
    // After the flip, byte j of the result holds column j of the input.
    function automatic logic [XLEN-1:0] bmatflip(input logic [XLEN-1:0] m);
        logic [XLEN-1:0] t;
        t = '0;
        for (int i = 0; i < BMAT_N; i++) begin
            for (int j = 0; j < BMAT_N; j++) begin
                t[BMAT_N*j + i] = m[BMAT_N*i + j];
            end
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmat_row.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bmat_row                                                |
// | Purpose  : One product row: row of rs1 against all 8 columns of    |
// |            rs2, reduced by XOR (GF(2)) or OR (Boolean semiring).   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module bmat_row
    import bmat_pkg::*;
(
    input  logic [BMAT_N-1:0] i_row,    // element (i,k) at bit k
    input  logic [XLEN-1:0]   i_cols,   // transposed rs2: byte j = column j
    input  logic              i_xoren,
    output logic [BMAT_N-1:0] o_row     // element (i,j) at bit j
);

    bmat_mode_e w_mode;
    assign w_mode = bmat_mode_e'(i_xoren);

    genvar j;
    generate
        for (j = 0; j < BMAT_N; j++) begin : g_col
            logic [BMAT_N-1:0] w_terms;
            // AND the row with column j, then reduce according to the mode
            always_comb begin
                w_terms  = i_row & i_cols[BMAT_N*j +: BMAT_N];
                o_row[j] = (w_mode == BMAT_XOR) ? (^w_terms) : (|w_terms);
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/simplebmat_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : simplebmat_core                                         |
// | Purpose  : Fully pipelined 64-bit bit-matrix multiply (bmatxor /   |
// |            bmator). One op per clock, registered result, 1 cycle   |
// |            latency, synchronous active-low reset of rd only.       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module simplebmat_core
    import bmat_pkg::*;
(
    input  logic            clock,
    input  logic            resetn,
    input  logic            xoren,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] rd
);

    logic [XLEN-1:0] w_cols;   // rs2 columns laid out as bytes
    logic [XLEN-1:0] w_prod;   // combinational product
    logic [XLEN-1:0] r_rd;

    assign w_cols = bmatflip(rs2);

    genvar i;
    generate
        for (i = 0; i < BMAT_N; i++) begin : g_row
            bmat_row u_row (
                .i_row   (rs1[BMAT_N*i +: BMAT_N]),
                .i_cols  (w_cols),
                .i_xoren (xoren),
                .o_row   (w_prod[BMAT_N*i +: BMAT_N])
            );
        end
    endgenerate

    // Output register; reset wins over the computed product
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rd <= '0;
        end else begin
            r_rd <= w_prod;
        end
    end

    assign rd = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_simplebmat_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_simplebmat_core                                      |
// | Purpose  : Self-checking bench for simplebmat_core against a       |
// |            counting-based matrix product model.                    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_simplebmat_core;

    logic        clock;
    logic        resetn;
    logic        xoren;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] rd;

    int n_cmp = 0;
    int n_mis = 0;

    simplebmat_core u_dut (
        .clock  (clock),
        .resetn (resetn),
        .xoren  (xoren),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: count the matching (i,k)&(k,j) pairs per output element;
    // XOR mode keeps the parity of the count, OR mode tests it for nonzero.
    function automatic logic [63:0] ref_mul(input logic x, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [63:0] r;
        int          cnt;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                cnt = 0;
                for (int k = 0; k < 8; k++) begin
                    if (a[8*i + k] && b[8*k + j]) cnt++;
                end
                r[8*i + j] = x ? ((cnt % 2) == 1) : (cnt > 0);
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one op, let the edge capture it, then check rd just after the edge
    task automatic step(input string tag, input logic rn, input logic x,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp);
        resetn = rn;
        xoren  = x;
        rs1    = a;
        rs2    = b;
        @(posedge clock);
        #1;
        chk(tag, rd, exp);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [63:0] a, b;
        logic        x;
        int          rst_at;

        // Reset with random operands for two cycles
        for (int c = 0; c < 2; c++) begin
            step("reset", 1'b0, 1'($urandom_range(0, 1)), rnd64(), rnd64(), 64'h0);
        end

        // Identity in both modes and both operand positions
        for (int m = 0; m < 2; m++) begin
            step("ident_rs2", 1'b1, 1'(m), 64'h0123456789ABCDEF, 64'h8040201008040201,
                 64'h0123456789ABCDEF);
            step("ident_rs1", 1'b1, 1'(m), 64'h8040201008040201, 64'h0123456789ABCDEF,
                 64'h0123456789ABCDEF);
        end

        // Mode difference and full reduction
        step("mode_xor", 1'b1, 1'b1, 64'h03, 64'h0101, 64'h0);
        step("mode_or",  1'b1, 1'b0, 64'h03, 64'h0101, 64'h01);
        step("full_xor", 1'b1, 1'b1, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        step("full_or",  1'b1, 1'b0, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFF);

        // Alternating modes back to back on the same random operands
        for (int c = 0; c < 8; c++) begin
            a = rnd64();
            b = rnd64();
            step("alt_xor", 1'b1, 1'b1, a, b, ref_mul(1'b1, a, b));
            step("alt_or",  1'b1, 1'b0, a, b, ref_mul(1'b0, a, b));
        end

        // Random stream with one mid-stream reset cycle
        rst_at = $urandom_range(100, 900);
        for (int n = 0; n < 1000; n++) begin
            a = rnd64();
            b = rnd64();
            x = 1'($urandom_range(0, 1));
            // Sparse operands now and then so OR mode sees zero results too
            if (n % 7 == 3) begin
                a = a & rnd64() & rnd64();
                b = b & rnd64() & rnd64();
            end
            if (n == rst_at) begin
                step("mid_reset", 1'b0, x, a, b, 64'h0);
            end else if (n == rst_at + 1) begin
                step("after_reset", 1'b1, x, a, b, ref_mul(x, a, b));
            end else begin
                step("stream", 1'b1, x, a, b, ref_mul(x, a, b));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
